// File: rtl/muxreg_pipe_if.sv
// Handshake and data bundle for the muxreg_pipe pipeline stage.
interface muxreg_pipe_if #(
    parameter int unsigned W    = 16,
    parameter int unsigned N    = 8,
    parameter int unsigned SELW = 3,
    parameter int unsigned CNTW = 8
);
    logic [N*W-1:0]  din;
    logic [SELW-1:0] sel;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [W-1:0]    q;
    logic            out_valid;
    logic            out_ready;
    logic            sel_err;
    logic [CNTW-1:0] xfer_cnt;

    // Upstream/downstream environment side
    modport master (
        output din, sel, in_valid, flush, out_ready,
        input  in_ready, q, out_valid, sel_err, xfer_cnt
    );

    // Pipeline stage side
    modport slave (
        input  din, sel, in_valid, flush, out_ready,
        output in_ready, q, out_valid, sel_err, xfer_cnt
    );
endinterface

// File: rtl/muxreg_pipe.sv
// N-input, W-bit multiplexed pipeline register with a 2-entry skid buffer,
// flush, sticky out-of-range select flag and delivered-word counter.
module muxreg_pipe #(
    parameter int unsigned W    = 16,
    parameter int unsigned N    = 8,
    parameter int unsigned SELW = 3,
    parameter int unsigned CNTW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    muxreg_pipe_if.slave  bus
);

    localparam int unsigned STW = 2;

    // Occupancy: EMPTY = nothing held, ONE = word in q, FULL = q and skid
    localparam logic [STW-1:0] EMPTY = 2'd0;
    localparam logic [STW-1:0] ONE   = 2'd1;
    localparam logic [STW-1:0] FULL  = 2'd2;

    logic [STW-1:0]  state;
    logic [STW-1:0]  state_d;
    logic [W-1:0]    q_r;
    logic [W-1:0]    q_d;
    logic [W-1:0]    skid_r;
    logic [W-1:0]    skid_d;
    logic            sel_err_r;
    logic            sel_err_d;
    logic [CNTW-1:0] cnt_r;
    logic [CNTW-1:0] cnt_d;

    logic [W-1:0]    cap;
    logic            sel_oor;
    logic            accept;
    logic            deliver;

    // Pick the addressed input lane; selects beyond the last lane yield zero
    always_comb begin
        cap = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (bus.sel == SELW'(i)) begin
                cap = bus.din[i*W +: W];
            end
        end
    end

    assign sel_oor = 32'(bus.sel) >= N;

    // in_ready is derived from state and RST only, never from out_ready
    assign bus.in_ready  = (state != FULL) & ~RST;
    assign bus.out_valid = (state != EMPTY);
    assign bus.q         = q_r;
    assign bus.sel_err   = sel_err_r;
    assign bus.xfer_cnt  = cnt_r;

    assign accept  = bus.in_valid & bus.in_ready;
    assign deliver = bus.out_valid & bus.out_ready;

    // Next-state and datapath update; flush drops everything but still counts a delivery
    always_comb begin
        state_d   = state;
        q_d       = q_r;
        skid_d    = skid_r;
        sel_err_d = sel_err_r;
        cnt_d     = cnt_r + CNTW'(deliver);

        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            if (accept && sel_oor) begin
                sel_err_d = 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        q_d     = cap;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        q_d = cap;
                    end else if (accept) begin
                        skid_d  = cap;
                        state_d = FULL;
                    end else if (deliver) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        q_d     = skid_r;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= EMPTY;
            q_r       <= '0;
            skid_r    <= '0;
            sel_err_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            state     <= state_d;
            q_r       <= q_d;
            skid_r    <= skid_d;
            sel_err_r <= sel_err_d;
            cnt_r     <= cnt_d;
        end
    end

endmodule

// File: doc/muxreg_pipe.md
Name: muxreg_pipe

Overview:
Parametrised N-input, W-bit multiplexed pipeline register for the CPU pipeline datapath. It generalises the fixed 8x16 load-enabled mux register into a valid/ready pipeline stage. A 2-entry skid buffer gives full throughput with a registered in_ready, and the stage adds flush, out-of-range select detection and a delivered-word counter.

Parameters:
W, 16, data width in bits
N, 8, number of data inputs (2..32)
SELW, 3, select width; must satisfy 2**SELW >= N
CNTW, 8, width of delivered-word counter

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous reset, active-high
din  in  N*W  packed inputs; input i = din[i*W +: W]
sel  in  SELW  input select, sampled on accept
in_valid  in  1  upstream has data
in_ready  out  1  stage can accept; accept = in_valid & in_ready
flush  in  1  discard all held data (pipeline kill)
q  out  W  output data (main register)
out_valid  out  1  q holds valid data
out_ready  in  1  downstream consumes; deliver = out_valid & out_ready
sel_err  out  1  sticky: an accepted transfer had sel >= N
xfer_cnt  out  CNTW  count of delivered words, wraps modulo 2**CNTW

Behaviour:
- Captured value: cap = din[sel*W +: W] if sel < N, else all-zero.
- The one clock is CLK; reset RST is synchronous and active-high.
- Reset (RST=1 at edge):
  - state <= EMPTY; q, skid, xfer_cnt <= 0; sel_err <= 0.
  - in_ready = 0 while RST is high.
- in_ready = (state != FULL) & ~RST; it depends only on registers and RST, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- States and transitions (no flush):
  - EMPTY: on accept, q <= cap and go to ONE; otherwise stay.
  - ONE:
    - accept & deliver: q <= cap, stay ONE.
    - accept & ~deliver: skid <= cap, go FULL.
    - ~accept & deliver: go EMPTY.
    - otherwise hold.
  - FULL: no accept is possible. On deliver, q <= skid and go ONE; otherwise hold.
- Latency: into EMPTY, word accepted at edge k is on q with out_valid=1 immediately after edge k (1 cycle). Sustained throughput is 1 word/cycle when out_ready stays high.
- Ordering: strictly FIFO. The skid word is never presented before the word in q.
- q and skid are stable while not being loaded; q is unchanged while out_valid=1 and out_ready=0.
- Flush (flush=1 at edge, RST=0):
  - Forces EMPTY. q and skid keep their values but are invalid.
  - A transfer presented in the same cycle completes its handshake (if in_ready=1) and is discarded: no load, no sel_err update.
  - A delivery in the same cycle still counts in xfer_cnt.
- Priority: RST > flush > normal.
- sel_err:
  - Set at the edge of any non-flushed accept with sel >= N.
  - Cleared only by RST. Never set when N == 2**SELW.
- xfer_cnt increments by 1 on every deliver and wraps 2**CNTW-1 -> 0.
- Reset mid-operation discards held words, and xfer_cnt returns to 0.

Test Plan:
1. Reset, then in_valid=1, sel=3, din input3=16'hBEEF, out_ready=1 -> next cycle q=16'hBEEF, out_valid=1; in_ready=1 throughout; xfer_cnt=1 one edge later.
2. Back-pressure: out_ready=0 and push A=16'h1111 (sel 0) then B=16'h2222 (sel 1) -> state FULL, in_ready=0, q=16'h1111 held. Raise out_ready -> q=16'h1111 delivered, then q=16'h2222, then out_valid=0; xfer_cnt=2.
3. Streaming: 20 random words with out_ready=1 every cycle -> one word out per cycle in order, no in_ready drop; xfer_cnt=20.
4. Out-of-range select: N=6, SELW=3, accept with sel=7 -> q=16'h0000, sel_err=1. It stays 1 through later valid transfers until RST.
5. Flush in FULL with concurrent in_valid: out_valid=0 and in_ready=1 next cycle; the concurrent word is not loaded. Next accept of 16'h00AA appears as q=16'h00AA.
6. Reset mid-stream in FULL with CNTW=4, after 15 deliveries + 2 (count wrapped to 1) -> at the RST edge out_valid=0, xfer_cnt=0, sel_err=0, q=0; in_ready=0 while RST=1.
